// File: rtl/ysyx_24080006_axi_rarb.sv
// Two-master to one-slave AXI read arbiter: IFU and LSU share one read port.
// One transaction in flight; round-robin on simultaneous requests, LSU favoured after reset.
module ysyx_24080006_axi_rarb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic [7:0]        ifu_arlen,
    input  logic [2:0]        ifu_arsize,
    input  logic [1:0]        ifu_arburst,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    output logic              ifu_rlast,

    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [7:0]        lsu_arlen,
    input  logic [2:0]        lsu_arsize,
    input  logic [1:0]        lsu_arburst,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    output logic              lsu_rlast,

    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,

    output logic [1:0]        grant,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid,
    // once raised, is expected to hold until that edge (the owner stays in AR if not).
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_e;

    state_e     state_q;
    logic       owner_lsu_q;
    logic       prio_lsu_q;
    logic [1:0] grant_q;

    logic pick_lsu;
    logic in_ar;
    logic in_r;

    assign pick_lsu = lsu_arvalid && (!ifu_arvalid || prio_lsu_q);
    assign in_ar    = (state_q == S_AR);
    assign in_r     = (state_q == S_R);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_lsu_q <= 1'b0;
            prio_lsu_q  <= 1'b1;
            grant_q     <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ifu_arvalid || lsu_arvalid) begin
                        owner_lsu_q <= pick_lsu;
                        grant_q     <= pick_lsu ? 2'b10 : 2'b01;
                        state_q     <= S_AR;
                    end
                end
                S_AR: begin
                    if (m_arvalid && m_arready) begin
                        state_q <= S_R;
                    end
                end
                S_R: begin
                    // Burst length is whatever the slave says via rlast; arlen is not tracked.
                    if (m_rvalid && m_rready && m_rlast) begin
                        state_q    <= S_IDLE;
                        grant_q    <= 2'b00;
                        prio_lsu_q <= ~owner_lsu_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign m_arvalid = in_ar && (owner_lsu_q ? lsu_arvalid : ifu_arvalid);
    assign m_araddr  = owner_lsu_q ? lsu_araddr  : ifu_araddr;
    assign m_arlen   = owner_lsu_q ? lsu_arlen   : ifu_arlen;
    assign m_arsize  = owner_lsu_q ? lsu_arsize  : ifu_arsize;
    assign m_arburst = owner_lsu_q ? lsu_arburst : ifu_arburst;

    assign ifu_arready = in_ar && !owner_lsu_q && m_arready;
    assign lsu_arready = in_ar &&  owner_lsu_q && m_arready;

    assign m_rready   = in_r && (owner_lsu_q ? lsu_rready : ifu_rready);
    assign ifu_rvalid = in_r && !owner_lsu_q && m_rvalid;
    assign lsu_rvalid = in_r &&  owner_lsu_q && m_rvalid;

    // Payload is broadcast; only rvalid carries ownership.
    assign ifu_rdata = m_rdata;
    assign ifu_rresp = m_rresp;
    assign ifu_rlast = m_rlast;
    assign lsu_rdata = m_rdata;
    assign lsu_rresp = m_rresp;
    assign lsu_rlast = m_rlast;

    assign grant     = grant_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_24080006_axi_rarb.sv
// Directed bench for the IFU/LSU read arbiter; the bench plays both masters and the slave.
module tb_ysyx_24080006_axi_rarb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [AW-1:0] ifu_araddr;
    logic [7:0]    ifu_arlen;
    logic [2:0]    ifu_arsize;
    logic [1:0]    ifu_arburst, ifu_rresp;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [AW-1:0] lsu_araddr;
    logic [7:0]    lsu_arlen;
    logic [2:0]    lsu_arsize;
    logic [1:0]    lsu_arburst, lsu_rresp;
    logic [DW-1:0] lsu_rdata;
    logic          m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst, m_rresp;
    logic [DW-1:0] m_rdata;
    logic [1:0]    grant, dbg_state;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AR   = 2'd1;
    localparam logic [1:0] ST_R    = 2'd2;

    ysyx_24080006_axi_rarb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .grant(grant), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One single-beat read from IDLE with requests already driven; slave accepts at once.
    task automatic txn(input string tag, input logic [1:0] exp_grant, input logic [31:0] exp_addr,
                       input logic [31:0] data, input logic [1:0] resp);
        chk({tag, "_idle_grant"}, grant, 2'b00);
        tick();
        chk({tag, "_ar_grant"}, grant, exp_grant);
        chk({tag, "_ar_addr"}, m_araddr, exp_addr);
        chk({tag, "_ar_valid"}, m_arvalid, 1'b1);
        tick();
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = data; m_rresp = resp;
        #1;
        chk({tag, "_ifu_rvalid"}, ifu_rvalid, exp_grant[0]);
        chk({tag, "_lsu_rvalid"}, lsu_rvalid, exp_grant[1]);
        chk({tag, "_rdata"}, exp_grant[1] ? lsu_rdata : ifu_rdata, data);
        chk({tag, "_rresp"}, exp_grant[1] ? lsu_rresp : ifu_rresp, resp);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk({tag, "_done_state"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        int b;
        logic rdy;
        reset = 1'b1;
        ifu_arvalid = 1'b1; ifu_araddr = '0; ifu_arlen = '0; ifu_arsize = 3'd2; ifu_arburst = 2'b01;
        lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_arlen = '0; lsu_arsize = 3'd2; lsu_arburst = 2'b01;
        ifu_rready = 1'b0; lsu_rready = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
        repeat (2) tick();
        chk("rst_grant", grant, 2'b00);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_m_arvalid", m_arvalid, 1'b0);
        chk("rst_m_rready", m_rready, 1'b0);
        chk("rst_ifu_arready", ifu_arready, 1'b0);
        ifu_arvalid = 1'b0;

        // Single IFU read
        tick();
        reset = 1'b0; m_arready = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
        tick();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; ifu_arlen = 8'd0;
        #1;
        chk("single_idle_m_arvalid", m_arvalid, 1'b0);
        chk("single_idle_arready", ifu_arready, 1'b0);
        tick();
        chk("single_m_arvalid", m_arvalid, 1'b1);
        chk("single_m_araddr", m_araddr, 32'h3000_0000);
        chk("single_grant_ar", grant, 2'b01);
        chk("single_ifu_arready", ifu_arready, 1'b1);
        chk("single_lsu_arready", lsu_arready, 1'b0);
        tick();
        ifu_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rlast = 1'b1;
        #1;
        chk("single_state_r", dbg_state, ST_R);
        chk("single_ifu_rvalid", ifu_rvalid, 1'b1);
        chk("single_ifu_rdata", ifu_rdata, 32'hDEAD_BEEF);
        chk("single_lsu_rvalid", lsu_rvalid, 1'b0);
        chk("single_lsu_rdata_bcast", lsu_rdata, 32'hDEAD_BEEF);
        chk("single_m_rready", m_rready, 1'b1);
        chk("single_r_m_arvalid", m_arvalid, 1'b0);
        chk("single_grant_r", grant, 2'b01);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("single_grant_end", grant, 2'b00);

        // Simultaneous requests after a fresh reset: LSU then IFU, then strict alternation
        reset = 1'b1;
        #1;
        reset = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h2000_0000;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0010;
        #1;
        txn("sim_lsu", 2'b10, 32'h8000_0010, 32'h1111_0000, 2'b00);
        txn("sim_ifu", 2'b01, 32'h2000_0000, 32'h2222_0000, 2'b10);
        for (int i = 0; i < 8; i++) begin
            txn($sformatf("alt%0d", i), (i % 2 == 0) ? 2'b10 : 2'b01,
                (i % 2 == 0) ? 32'h8000_0010 : 32'h2000_0000, 32'h5000_0000 + i, i[1:0]);
        end
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;

        // IFU 4-beat burst with a one-cycle rready stall on beat 2
        ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_1000; ifu_arlen = 8'd3;
        tick();
        chk("burst_grant", grant, 2'b01);
        chk("burst_arlen", m_arlen, 8'd3);
        tick();
        ifu_arvalid = 1'b0;
        b = 0;
        for (int c = 0; c < 5; c++) begin
            rdy = (c != 1);
            ifu_rready = rdy; m_rvalid = 1'b1;
            m_rdata = 32'hA000_0000 + b; m_rlast = (b == 3);
            #1;
            chk($sformatf("burst_c%0d_m_rready", c), m_rready, rdy);
            chk($sformatf("burst_c%0d_rvalid", c), ifu_rvalid, 1'b1);
            chk($sformatf("burst_c%0d_rdata", c), ifu_rdata, 32'hA000_0000 + b);
            chk($sformatf("burst_c%0d_state", c), dbg_state, ST_R);
            if (rdy) b++;
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; ifu_rready = 1'b1;
        #1;
        chk("burst_end_state", dbg_state, ST_IDLE);

        // LSU address phase stalled by the slave for five cycles
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0040; m_arready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_m_arvalid", c), m_arvalid, 1'b1);
            chk($sformatf("stall%0d_m_araddr", c), m_araddr, 32'h0000_0040);
            chk($sformatf("stall%0d_grant", c), grant, 2'b10);
            chk($sformatf("stall%0d_state", c), dbg_state, ST_AR);
            chk($sformatf("stall%0d_lsu_arready", c), lsu_arready, 1'b0);
            tick();
        end
        m_arready = 1'b1;
        #1;
        chk("stall_lsu_arready", lsu_arready, 1'b1);
        tick();
        lsu_arvalid = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
        #1;
        chk("stall_lsu_rvalid", lsu_rvalid, 1'b1);
        chk("stall_state_r", dbg_state, ST_R);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("stall_end_state", dbg_state, ST_IDLE);

        // Reset during beat 2 of a 4-beat IFU burst, LSU waiting
        ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_5000; ifu_arlen = 8'd3;
        tick();
        chk("rstmid_grant_ar", grant, 2'b01);
        tick();
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_6000;
        m_rvalid = 1'b1; m_rdata = 32'hB000_0000; m_rlast = 1'b0;
        #1;
        chk("rstmid_no_ar_in_r", lsu_arready, 1'b0);
        chk("rstmid_m_arvalid", m_arvalid, 1'b0);
        tick();
        m_rdata = 32'hB000_0001;
        #1;
        chk("rstmid_beat2_rready", m_rready, 1'b1);
        reset = 1'b1;
        #1;
        chk("rstmid_grant", grant, 2'b00);
        chk("rstmid_m_rready", m_rready, 1'b0);
        chk("rstmid_ifu_rvalid", ifu_rvalid, 1'b0);
        chk("rstmid_state", dbg_state, ST_IDLE);
        ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_5000;
        tick();
        reset = 1'b0; m_rvalid = 1'b0;
        #1;
        chk("rstmid_post_grant", grant, 2'b00);
        tick();
        chk("rstmid_lsu_first", grant, 2'b10);
        chk("rstmid_lsu_addr", m_araddr, 32'h0000_6000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
